// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM datapath stages: Q4.20 format defaults,
// saturation constants and the gate MAC state encoding.
package lstm_pkg;

    localparam int unsigned LSTM_WIDTH = 24;
    localparam int unsigned LSTM_FRAC  = 20;

    localparam logic [LSTM_WIDTH-1:0] Q_ONE   = 24'h100000;
    localparam logic [LSTM_WIDTH-1:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [LSTM_WIDTH-1:0] SAT_MIN = 24'h800000;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/lstm_sat_shift.sv
// Combinational rescale of a wide signed accumulator to a WIDTH-bit word:
// arithmetic shift by FRAC, optional round half-up (LSTM_GATE_MAC_ROUND_EN), clamp.
module lstm_sat_shift #(
    parameter int unsigned IN_W  = 57,
    parameter int unsigned OUT_W = lstm_pkg::LSTM_WIDTH,
    parameter int unsigned FRAC  = lstm_pkg::LSTM_FRAC
) (
    input  logic [IN_W-1:0]  i_acc,
    output logic [OUT_W-1:0] o_sat_c
);

    localparam int unsigned EW = IN_W + 1;

    localparam logic signed [EW-1:0] MAX_V = EW'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

    logic signed [EW-1:0] ext_c;
    logic signed [EW-1:0] shr_c;

    // One guard bit so the rounding add can never wrap.
    always_comb begin
        ext_c = {i_acc[IN_W-1], i_acc};
`ifdef LSTM_GATE_MAC_ROUND_EN
        ext_c = ext_c + (EW'(1) << (FRAC - 1));
`endif
        shr_c = ext_c >>> FRAC;
        if (shr_c > MAX_V) begin
            o_sat_c = MAX_V[OUT_W-1:0];
        end else if (shr_c < MIN_V) begin
            o_sat_c = MIN_V[OUT_W-1:0];
        end else begin
            o_sat_c = shr_c[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/lstm_gate_mac.sv
// Streaming gate pre-activation MAC: z = b + sum(w[k]*x[k]) over N elements,
// saturated to Q4.20. Build option LSTM_GATE_MAC_ROUND_EN selects round half-up.
module lstm_gate_mac
    import lstm_pkg::*;
#(
    parameter int unsigned WIDTH = LSTM_WIDTH,
    parameter int unsigned FRAC  = LSTM_FRAC,
    parameter int unsigned N     = 8,
    parameter int unsigned CW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_w,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_acc
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + CW + 1;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 o_valid_q, o_valid_d;
    logic                 o_ready_q, o_ready_d;
    logic [WIDTH-1:0]     o_acc_q, o_acc_d;

    logic signed [PW-1:0] prod_c;
    logic signed [AW-1:0] bias_c;
    logic                 accept_c;

    always_comb begin
        prod_c   = $signed(i_x) * $signed(i_w);
        bias_c   = AW'($signed(i_b)) <<< FRAC;
        accept_c = i_valid & o_ready_q & (state_q == ACC);
    end

    // Next-state: accumulate while in ACC, hold the result in DONE until taken.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        o_valid_d = o_valid_q;
        o_ready_d = o_ready_q;
        unique case (state_q)
            ACC: begin
                if (accept_c) begin
                    if (count_q == '0) begin
                        acc_d = bias_c + AW'(prod_c);
                    end else begin
                        acc_d = acc_q + AW'(prod_c);
                    end
                    if (count_q == CW'(N - 1)) begin
                        count_d   = '0;
                        state_d   = DONE;
                        o_valid_d = 1'b1;
                        o_ready_d = 1'b0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d   = ACC;
                    o_valid_d = 1'b0;
                    o_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    lstm_sat_shift #(
        .IN_W  (AW),
        .OUT_W (WIDTH),
        .FRAC  (FRAC)
    ) u_sat (
        .i_acc   (acc_d),
        .o_sat_c (o_acc_d)
    );

    // o_acc registers the saturated next accumulator, so it is stable throughout DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACC;
            count_q   <= '0;
            acc_q     <= '0;
            o_valid_q <= 1'b0;
            o_ready_q <= 1'b1;
            o_acc_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            o_valid_q <= o_valid_d;
            o_ready_q <= o_ready_d;
            o_acc_q   <= o_acc_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_ready = o_ready_q;
    assign o_acc   = o_acc_q;

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Directed bench for lstm_gate_mac: an N=4 instance for the dot-product cases
// and an N=1 instance for the rounding corner cases.
module tb_lstm_gate_mac;
    import lstm_pkg::*;

    logic clk;
    logic rst;

    logic        v4, rdy4, ov4, ir4;
    logic [23:0] x4, w4, b4, acc4;
    logic        v1, rdy1, ov1, ir1;
    logic [23:0] x1, w1, b1, acc1;

    int n_vec;
    int n_err;

    lstm_gate_mac #(.WIDTH(24), .FRAC(20), .N(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_valid(v4), .o_ready(rdy4), .i_x(x4), .i_w(w4),
        .i_b(b4), .o_valid(ov4), .i_ready(ir4), .o_acc(acc4)
    );

    lstm_gate_mac #(.WIDTH(24), .FRAC(20), .N(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .o_ready(rdy1), .i_x(x1), .i_w(w1),
        .i_b(b1), .o_valid(ov1), .i_ready(ir1), .o_acc(acc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One element into the N=4 instance; returns at the next negedge.
    task automatic push4(input string tag, input logic [23:0] b, input logic [23:0] x,
                         input logic [23:0] w);
        check({tag, "_ready"}, 32'(rdy4), 32'd1);
        v4 = 1'b1; x4 = x; w4 = w; b4 = b;
        @(negedge clk);
        v4 = 1'b0; x4 = 24'h5A5A5A; w4 = 24'h3C3C3C; b4 = 24'h7FFFFF;
    endtask

    // Full vector with constant x/w; bias only on k=0, junk bias elsewhere.
    task automatic vec4(input string tag, input logic [23:0] b, input logic [23:0] x,
                        input logic [23:0] w, input logic [23:0] exp, input int gap);
        for (int k = 0; k < 4; k++) begin
            push4(tag, (k == 0) ? b : 24'h7FFFFF, x, w);
            if (k == 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                end
            end
            if (k < 3) check({tag, "_early_valid"}, 32'(ov4), 32'd0);
        end
        check({tag, "_valid"}, 32'(ov4), 32'd1);
        check({tag, "_ready_done"}, 32'(rdy4), 32'd0);
        check({tag, "_acc"}, 32'(acc4), 32'(exp));
    endtask

    task automatic release4(input string tag);
        ir4 = 1'b1;
        @(negedge clk);
        ir4 = 1'b0;
        check({tag, "_rel_valid"}, 32'(ov4), 32'd0);
        check({tag, "_rel_ready"}, 32'(rdy4), 32'd1);
    endtask

    task automatic one1(input string tag, input logic [23:0] x, input logic [23:0] w,
                        input logic [23:0] exp);
        check({tag, "_ready"}, 32'(rdy1), 32'd1);
        v1 = 1'b1; x1 = x; w1 = w; b1 = 24'h000000;
        @(negedge clk);
        v1 = 1'b0;
        check({tag, "_valid"}, 32'(ov1), 32'd1);
        check({tag, "_acc"}, 32'(acc1), 32'(exp));
        ir1 = 1'b1;
        @(negedge clk);
        ir1 = 1'b0;
        check({tag, "_rel_valid"}, 32'(ov1), 32'd0);
    endtask

    logic [23:0] held;

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        v4 = 1'b0; x4 = '0; w4 = '0; b4 = '0; ir4 = 1'b0;
        v1 = 1'b0; x1 = '0; w1 = '0; b1 = '0; ir1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(ov4), 32'd0);
        check("rst_ready", 32'(rdy4), 32'd1);
        check("rst_acc", 32'(acc4), 32'd0);
        check("rst_valid1", 32'(ov1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 4 * (1.0 * 0.5) = 2.0, with an idle gap mid-vector
        vec4("two", 24'h000000, 24'h100000, 24'h080000, 24'h200000, 2);
        release4("two");

        // 0.5 + 4 * (-1.0 * 0.25) = -0.5, then backpressure hold
        vec4("neg", 24'h080000, 24'hF00000, 24'h040000, 24'hF80000, 0);
        held = acc4;
        for (int c = 0; c < 3; c++) begin
            v4 = 1'b1; x4 = 24'(c * 24'h111111 + 24'h123456); w4 = 24'h100000;
            @(negedge clk);
            check("bp_valid", 32'(ov4), 32'd1);
            check("bp_ready", 32'(rdy4), 32'd0);
            check("bp_acc", 32'(acc4), 32'(held));
        end
        // Release with i_valid still high: that element must not be taken.
        ir4 = 1'b1;
        @(negedge clk);
        ir4 = 1'b0; v4 = 1'b0;
        check("bp_rel_valid", 32'(ov4), 32'd0);
        check("bp_rel_ready", 32'(rdy4), 32'd1);

        // 4 * 49 saturates high; negated weight saturates low
        vec4("satp", 24'h000000, 24'h700000, 24'h700000, SAT_MAX, 0);
        release4("satp");
        vec4("satn", 24'h000000, 24'h700000, 24'h900000, SAT_MIN, 0);
        release4("satn");

        // Abort after 2 elements; new vector must not see the partial sum
        push4("abort", 24'h000000, 24'h700000, 24'h700000);
        push4("abort", 24'h7FFFFF, 24'h700000, 24'h700000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(ov4), 32'd0);
        check("abort_ready", 32'(rdy4), 32'd1);
        check("abort_acc", 32'(acc4), 32'd0);
        vec4("four", 24'h000000, 24'h100000, 24'h100000, 24'h400000, 0);
        release4("four");

        // N=1 LSB cases: +2^-21 and -2^-21
`ifdef LSTM_GATE_MAC_ROUND_EN
        one1("lsb_pos", 24'h000001, 24'h080000, 24'h000001);
        one1("lsb_neg", 24'hFFFFFF, 24'h080000, 24'h000000);
`else
        one1("lsb_pos", 24'h000001, 24'h080000, 24'h000000);
        one1("lsb_neg", 24'hFFFFFF, 24'h080000, 24'hFFFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
